// File: rtl/mul_seq_arb.sv
// Two-requester 32x32 multiplier built on one shared 16x16 unsigned multiplier.
// Each operation takes four partial products, accumulates them, then holds the result until it is taken.
module mul_seq_arb #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_signed,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_id,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_en,
  input  logic [31:0] mul_p,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // reqN_ready never depends on anything but IDLE state, arbitration and reqN_valid.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [2:0] LAT      = 3'(MUL_LATENCY);
  localparam logic [2:0] LAST_CNT = 3'(3 + MUL_LATENCY);

  state_t      state, state_nx;
  logic        last;
  logic [31:0] a_mag, b_mag;
  logic        neg, id;
  logic [63:0] acc;
  logic [2:0]  cnt;

  logic        grant, accept, busy, acc_hit;
  logic [31:0] sel_a, sel_b;
  logic        sel_s;
  logic [2:0]  acc_k;
  logic [5:0]  shamt;
  logic [63:0] addend;

  // Tie goes to whoever was not served last; a lone requester always wins.
  assign grant  = (req0_valid & req1_valid) ? ~last : ~req0_valid;
  assign accept = (state == IDLE) & (req0_valid | req1_valid);
  assign sel_a  = grant ? req1_a : req0_a;
  assign sel_b  = grant ? req1_b : req0_b;
  assign sel_s  = grant ? req1_signed : req0_signed;

  // cnt counts cycles since the operation started; step k's product returns at cnt == k + LAT.
  assign busy    = (state == ISSUE) | (state == DRAIN);
  assign acc_k   = cnt - LAT;
  assign acc_hit = busy & (cnt >= LAT) & (acc_k <= 3'd3);
  assign addend  = {32'b0, mul_p} << shamt;

  always_comb begin
    shamt = 6'd16;
    if (acc_k == 3'd0) shamt = 6'd0;
    else if (acc_k == 3'd3) shamt = 6'd32;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      acc   <= '0;
      cnt   <= '0;
      a_mag <= '0;
      b_mag <= '0;
      neg   <= 1'b0;
      id    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            a_mag <= (sel_s & sel_a[31]) ? -sel_a : sel_a;
            b_mag <= (sel_s & sel_b[31]) ? -sel_b : sel_b;
            neg   <= sel_s & (sel_a[31] ^ sel_b[31]);
            id    <= grant;
            last  <= grant;
            acc   <= '0;
          end
        end
        ISSUE, DRAIN: begin
          cnt <= cnt + 3'd1;
          if (acc_hit) acc <= acc + addend;
        end
        DONE: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_id     = 1'b0;
    mul_en     = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    case (state)
      IDLE: begin
        req0_ready = ~reset & ~grant & req0_valid;
        req1_ready = ~reset & grant & req1_valid;
        if (accept) state_nx = ISSUE;
      end
      ISSUE: begin
        mul_en = 1'b1;
        mul_a  = cnt[1] ? a_mag[31:16] : a_mag[15:0];
        mul_b  = cnt[0] ? b_mag[31:16] : b_mag[15:0];
        if (cnt == 3'd3) state_nx = DRAIN;
      end
      DRAIN: begin
        // The final DRAIN cycle only waits for the last product, so the pipeline is frozen.
        mul_en = (cnt != LAST_CNT);
        if (cnt == LAST_CNT) state_nx = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = neg ? -acc : acc;
        rsp_id    = id;
        if (rsp_ready) state_nx = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

endmodule
